// File: rtl/bram_burst_master_if.sv
// Command, write-stream, read-stream and BRAM-port signals of bram_burst_master.
// Names are from the master's point of view (i_ = into the master).
interface bram_burst_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = ADDR_WIDTH
);
   logic                  i_cmd_valid;
   logic                  o_cmd_ready;
   logic                  i_cmd_write;
   logic [ADDR_WIDTH-1:0] i_cmd_addr;
   logic [LEN_WIDTH-1:0]  i_cmd_len;

   logic                  i_wr_valid;
   logic                  o_wr_ready;
   logic [DATA_WIDTH-1:0] i_wr_data;

   logic                  o_rd_valid;
   logic                  i_rd_ready;
   logic [DATA_WIDTH-1:0] o_rd_data;

   logic                  o_busy;
   logic                  o_done;

   logic                  o_bram_en;
   logic                  o_bram_we;
   logic [ADDR_WIDTH-1:0] o_bram_addr;
   logic [DATA_WIDTH-1:0] o_bram_din;
   logic [DATA_WIDTH-1:0] i_bram_dout;

   modport master (
      input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
      input  i_wr_valid, i_wr_data, i_rd_ready, i_bram_dout,
      output o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data,
      output o_busy, o_done, o_bram_en, o_bram_we, o_bram_addr, o_bram_din
   );

   modport slave (
      output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
      output i_wr_valid, i_wr_data, i_rd_ready, i_bram_dout,
      input  o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data,
      input  o_busy, o_done, o_bram_en, o_bram_we, o_bram_addr, o_bram_din
   );
endinterface

// File: rtl/bram_burst_master.sv
// Burst initiator for one BRAM port: command-driven write/read bursts with a
// 4-entry read-return FIFO so the read stream can be backpressured losslessly.
module bram_burst_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = ADDR_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   bram_burst_master_if.master  bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_READ = 2'd2} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_remain;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_acc_cnt;
   logic                  r_issue_active;
   logic                  r_wr_done;
   logic                  r_rd_pending;
   logic [1:0]            r_inflight;

   logic                  r_bram_en;
   logic                  r_bram_we;
   logic [ADDR_WIDTH-1:0] r_bram_addr;
   logic [DATA_WIDTH-1:0] r_bram_din;

   logic [DATA_WIDTH-1:0] r_fifo_mem [4];
   logic [1:0]            r_wptr;
   logic [1:0]            r_rptr;
   logic [2:0]            r_fifo_cnt;

   logic                  w_cmd_ready;
   logic                  w_cmd_fire;
   logic                  w_wr_ready;
   logic                  w_wr_fire;
   logic                  w_rd_valid;
   logic                  w_pop;
   logic                  w_rd_last;
   logic                  w_issue;
   logic                  w_done;
   logic [3:0]            w_occ;
   logic [DATA_WIDTH-1:0] w_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_cmd_fire) w_state_next = bus.i_cmd_write ? S_WRITE : S_READ;
         S_WRITE: if (w_wr_fire && (r_remain == '0)) w_state_next = S_IDLE;
         S_READ:  if (w_rd_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Write-done cycle holds off commands so the next one lands after o_done.
   always_comb begin
      w_cmd_ready = (r_state == S_IDLE) && !r_wr_done;
      w_cmd_fire  = w_cmd_ready && bus.i_cmd_valid;
      w_wr_ready  = (r_state == S_WRITE);
      w_wr_fire   = w_wr_ready && bus.i_wr_valid;
      w_rd_valid  = (r_fifo_cnt != 3'd0);
      w_rd_data   = w_rd_valid ? r_fifo_mem[r_rptr] : '0;
      w_pop       = w_rd_valid && bus.i_rd_ready;
      w_rd_last   = (r_state == S_READ) && w_pop && (r_acc_cnt == r_len) && !i_rst;
      w_occ       = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {3'b000, w_pop};
      w_issue     = (r_state == S_READ) && r_issue_active && (w_occ < 4'd4);
      w_done      = r_wr_done || w_rd_last;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr         <= '0;
         r_remain       <= '0;
         r_len          <= '0;
         r_acc_cnt      <= '0;
         r_issue_active <= 1'b0;
         r_wr_done      <= 1'b0;
         r_rd_pending   <= 1'b0;
         r_inflight     <= 2'd0;
         r_bram_en      <= 1'b0;
         r_bram_we      <= 1'b0;
         r_bram_addr    <= '0;
         r_bram_din     <= '0;
         r_wptr         <= 2'd0;
         r_rptr         <= 2'd0;
         r_fifo_cnt     <= 3'd0;
      end else begin
         r_bram_en    <= 1'b0;
         r_bram_we    <= 1'b0;
         r_wr_done    <= 1'b0;
         r_rd_pending <= r_bram_en && !r_bram_we;
         if (w_cmd_fire) begin
            r_addr         <= bus.i_cmd_addr;
            r_remain       <= bus.i_cmd_len;
            r_len          <= bus.i_cmd_len;
            r_acc_cnt      <= '0;
            r_issue_active <= !bus.i_cmd_write;
         end
         if (w_wr_fire) begin
            r_bram_en   <= 1'b1;
            r_bram_we   <= 1'b1;
            r_bram_addr <= r_addr;
            r_bram_din  <= bus.i_wr_data;
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            if (r_remain == '0) r_wr_done <= 1'b1;
            else                r_remain  <= r_remain - LEN_WIDTH'(1);
         end
         if (w_issue) begin
            r_bram_en   <= 1'b1;
            r_bram_addr <= r_addr;
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            if (r_remain == '0) r_issue_active <= 1'b0;
            else                r_remain       <= r_remain - LEN_WIDTH'(1);
         end
         // inflight spans the strobe cycle and the dout cycle of each read
         r_inflight <= r_inflight + {1'b0, w_issue} - {1'b0, r_rd_pending};
         if (w_pop && !w_rd_last) r_acc_cnt <= r_acc_cnt + LEN_WIDTH'(1);
         if (r_rd_pending) r_wptr <= r_wptr + 2'd1;
         if (w_pop)        r_rptr <= r_rptr + 2'd1;
         r_fifo_cnt <= r_fifo_cnt + {2'b00, r_rd_pending} - {2'b00, w_pop};
      end
   end

   always_ff @(posedge i_clk) begin
      if (r_rd_pending) r_fifo_mem[r_wptr] <= bus.i_bram_dout;
   end

   assign bus.o_cmd_ready = w_cmd_ready;
   assign bus.o_wr_ready  = w_wr_ready;
   assign bus.o_rd_valid  = w_rd_valid;
   assign bus.o_rd_data   = w_rd_data;
   assign bus.o_busy      = (r_state != S_IDLE);
   assign bus.o_done      = w_done;
   assign bus.o_bram_en   = r_bram_en;
   assign bus.o_bram_we   = r_bram_we;
   assign bus.o_bram_addr = r_bram_addr;
   assign bus.o_bram_din  = r_bram_din;
endmodule

// File: tb/tb_bram_burst_master.sv
// Directed + randomized bench for bram_burst_master with a BRAM model and a
// command-level reference memory.
module tb_bram_burst_master;
   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int LW    = 10;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bram_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   bram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   logic [DW-1:0] bram    [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] wq [$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM port model: one-cycle registered read
   always @(posedge clk) begin
      if (bus.o_bram_en) begin
         if (bus.o_bram_we) bram[bus.o_bram_addr] <= bus.o_bram_din;
         bus.i_bram_dout <= bram[bus.o_bram_addr];
      end
   end

   int            st_cyc [$];
   logic          st_we  [$];
   logic [AW-1:0] st_addr[$];
   logic [DW-1:0] st_din [$];
   int            rd_cyc [$];
   logic [DW-1:0] rd_data[$];
   int            dn_cyc [$];
   int            n_issued = 0;
   int            n_acc = 0;
   int            max_out = 0;
   int            stab_err = 0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         n_issued  = 0;
         n_acc     = 0;
         prev_hold = 1'b0;
      end else begin
         if (bus.o_bram_en && !bus.o_bram_we) n_issued++;
         if (n_issued - n_acc > max_out) max_out = n_issued - n_acc;
         if (prev_hold && (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== prev_data)) stab_err++;
         if (bus.o_rd_valid && bus.i_rd_ready) begin
            n_acc++;
            rd_cyc.push_back(cyc);
            rd_data.push_back(bus.o_rd_data);
         end
         prev_hold = bus.o_rd_valid && !bus.i_rd_ready;
         prev_data = bus.o_rd_data;
      end
      if (bus.o_bram_en) begin
         st_cyc.push_back(cyc);
         st_we.push_back(bus.o_bram_we);
         st_addr.push_back(bus.o_bram_addr);
         st_din.push_back(bus.o_bram_din);
      end
      if (bus.o_done) dn_cyc.push_back(cyc);
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random(input int n);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom());
   endtask

   task automatic send_cmd(input logic wr, input int a, input int l, output int c0);
      int k;
      k = 0;
      while (bus.o_cmd_ready !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      check("cmd_ready_wait", bus.o_cmd_ready, 1);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_write = wr;
      bus.i_cmd_addr  = AW'(a);
      bus.i_cmd_len   = LW'(l);
      c0 = cyc;
      tick();
      bus.i_cmd_valid = 1'b0;
   endtask

   task automatic do_write(input int a, input int l, input bit poke);
      int   c0, k, idx, sb, db;
      logic fire;
      sb = st_cyc.size();
      db = dn_cyc.size();
      send_cmd(1'b1, a, l, c0);
      idx = 0;
      k   = 0;
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = wq[0];
      while (idx <= l && k < 4 * (l + 1) + 20) begin
         if (poke && k == 0) begin
            bus.i_cmd_valid = 1'b1;
            bus.i_cmd_write = 1'b0;
         end
         if (k == 1) bus.i_cmd_valid = 1'b0;
         @(negedge clk);
         fire = bus.o_wr_ready && bus.i_wr_valid;
         tick();
         k++;
         if (fire) begin
            idx++;
            if (idx <= l) bus.i_wr_data = wq[idx];
         end
      end
      bus.i_wr_valid  = 1'b0;
      bus.i_cmd_valid = 1'b0;
      check("wr_words_accepted", idx, l + 1);
      for (int i = 0; i <= l; i++) ref_mem[(a + i) % DEPTH] = wq[i];
      k = 0;
      while (dn_cyc.size() == db && k < 20) begin
         tick();
         k++;
      end
      repeat (3) tick();
      check("wr_strobe_count", st_cyc.size() - sb, l + 1);
      for (int i = 0; i <= l && sb + i < st_cyc.size(); i++) begin
         check("wr_addr", st_addr[sb + i], (a + i) % DEPTH);
         check("wr_we", st_we[sb + i], 1);
         check("wr_din", st_din[sb + i], wq[i]);
         check("wr_cycle", st_cyc[sb + i], c0 + 2 + i);
      end
      check("wr_done_count", dn_cyc.size() - db, 1);
      if (dn_cyc.size() > db) check("wr_done_cycle", dn_cyc[db], c0 + 2 + l);
      check("wr_idle_after", bus.o_busy, 0);
      $display("write burst addr=%03h len=%0d cmd_cycle=%0d poke=%0d", a, l, c0, poke);
   endtask

   task automatic do_read(input int a, input int l, input bit bp, input bit poke);
      int c0, k, sb, rb, db;
      sb = st_cyc.size();
      rb = rd_cyc.size();
      db = dn_cyc.size();
      bus.i_rd_ready = 1'b1;
      send_cmd(1'b0, a, l, c0);
      k = 0;
      while (dn_cyc.size() == db && k < 8 * (l + 1) + 50) begin
         if (bp) bus.i_rd_ready = ($urandom_range(0, 2) == 0);
         if (poke && k == 0) begin
            bus.i_cmd_valid = 1'b1;
            bus.i_cmd_write = 1'b1;
            bus.i_cmd_addr  = '0;
            bus.i_cmd_len   = '0;
         end
         if (k == 2) bus.i_cmd_valid = 1'b0;
         tick();
         k++;
      end
      bus.i_cmd_valid = 1'b0;
      bus.i_rd_ready  = 1'b1;
      repeat (3) tick();
      check("rd_done_count", dn_cyc.size() - db, 1);
      check("rd_word_count", rd_cyc.size() - rb, l + 1);
      for (int i = 0; i <= l && rb + i < rd_cyc.size(); i++) begin
         check("rd_data", rd_data[rb + i], ref_mem[(a + i) % DEPTH]);
         if (!bp) check("rd_cycle", rd_cyc[rb + i], c0 + 4 + i);
      end
      if (dn_cyc.size() > db && rb + l < rd_cyc.size())
         check("rd_done_cycle", dn_cyc[db], rd_cyc[rb + l]);
      check("rd_strobe_count", st_cyc.size() - sb, l + 1);
      for (int i = 0; i <= l && sb + i < st_cyc.size(); i++) begin
         check("rd_addr", st_addr[sb + i], (a + i) % DEPTH);
         check("rd_we", st_we[sb + i], 0);
      end
      check("rd_outstanding_le4", max_out <= 4, 1);
      check("rd_hold_stable", stab_err, 0);
      check("rd_idle_after", bus.o_busy, 0);
      $display("read burst addr=%03h len=%0d cmd_cycle=%0d backpressure=%0d poke=%0d",
               a, l, c0, bp, poke);
   endtask

   initial begin
      int c0, db, rb, a, l;
      for (int i = 0; i < DEPTH; i++) begin
         bram[i]    = '0;
         ref_mem[i] = '0;
      end
      rst             = 1'b1;
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_write = 1'b0;
      bus.i_cmd_addr  = '0;
      bus.i_cmd_len   = '0;
      bus.i_wr_valid  = 1'b0;
      bus.i_wr_data   = '0;
      bus.i_rd_ready  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      check("rst_cmd_ready", bus.o_cmd_ready, 1);
      check("rst_wr_ready", bus.o_wr_ready, 0);
      check("rst_rd_valid", bus.o_rd_valid, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_bram_en", bus.o_bram_en, 0);
      check("rst_bram_we", bus.o_bram_we, 0);
      check("rst_bram_addr", bus.o_bram_addr, 0);
      check("rst_bram_din", bus.o_bram_din, 0);
      check("rst_rd_data", bus.o_rd_data, 0);
      $display("reset values checked");

      wq = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
      do_write(12'h010, 3, 1'b0);
      do_read(12'h010, 3, 1'b0, 1'b0);

      fill_random(16);
      do_write(12'h100, 15, 1'b0);
      do_read(12'h100, 15, 1'b1, 1'b0);

      fill_random(4);
      do_write(12'h3FE, 3, 1'b0);
      do_read(12'h3FE, 3, 1'b0, 1'b0);

      // reset lands in the third cycle of a len-7 read
      db = dn_cyc.size();
      rb = rd_cyc.size();
      bus.i_rd_ready = 1'b1;
      send_cmd(1'b0, 12'h010, 7, c0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_bram_en", bus.o_bram_en, 0);
      check("midrst_rd_valid", bus.o_rd_valid, 0);
      check("midrst_cmd_ready", bus.o_cmd_ready, 1);
      check("midrst_busy", bus.o_busy, 0);
      repeat (4) tick();
      check("midrst_no_done", dn_cyc.size() - db, 0);
      check("midrst_no_data", rd_cyc.size() - rb, 0);
      $display("reset mid-read at cmd_cycle=%0d", c0);
      do_read(12'h010, 0, 1'b0, 1'b0);

      fill_random(1);
      do_write(12'h055, 0, 1'b1);
      do_read(12'h055, 0, 1'b0, 1'b1);

      fill_random(DEPTH);
      do_write(12'h200, DEPTH - 1, 1'b0);
      do_read(12'h200, DEPTH - 1, 1'b1, 1'b0);

      for (int t = 0; t < 3; t++) begin
         a = $urandom_range(0, DEPTH - 1);
         l = $urandom_range(0, 40);
         fill_random(l + 1);
         do_write(a, l, 1'b0);
         do_read(a, l, 1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
